// File: rtl/aes_dec_iter_ctrl_pkg.sv
// rtl/aes_dec_iter_ctrl_pkg.sv - shared constants and helpers for the iterative AES inverse-cipher sequencer
//
// Contents:
//   AES_BLK_W            block width (128)
//   S_IDLE/S_RUN/S_DONE  sequencer state encoding
//   key_at(r)            LSB index of round key r inside the packed expandedkeys vector
package aes_dec_iter_ctrl_pkg;

  localparam int AES_BLK_W = 128;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic int key_at(input int r);
    return r * AES_BLK_W;
  endfunction

endpackage

// File: rtl/aes_dec_key_mux.sv
// rtl/aes_dec_key_mux.sv - combinational round-key selector indexed by the round counter
//
// Ports:
//   expandedkeys  in   all round keys, key r at bits [r*128 +: 128]
//   cnt           in   current round counter
//   key           out  selected 128-bit round key
module aes_dec_key_mux
  import aes_dec_iter_ctrl_pkg::*;
#(
  parameter int NumRounds = 14,
  parameter int CW        = $clog2(NumRounds + 1)
) (
  input  logic [AES_BLK_W*(NumRounds+1)-1:0] expandedkeys,
  input  logic [CW-1:0]                      cnt,
  output logic [AES_BLK_W-1:0]               key
);

  always_comb begin
    key = '0;
    for (int r = 0; r <= NumRounds; r++) begin
      if (cnt == CW'(r)) begin
        key = expandedkeys[key_at(r) +: AES_BLK_W];
      end
    end
  end

endmodule

// File: rtl/aes_dec_iter_ctrl.sv
// rtl/aes_dec_iter_ctrl.sv - iterative sequencer driving one shared inverse-round datapath
//
// Optional build macro: AES_DEC_ROUND_TRACE_EN (simulation-only round trace, no port changes)
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready/in_data    ciphertext input handshake
//   expandedkeys                 round keys (held stable while a block runs)
//   sbox_seed                    S-box seed, latched on accept
//   rnd_state/rnd_key/rnd_num    current state, key and round number to the datapath
//   rnd_final/rnd_seed           final-round flag and latched seed to the datapath
//   rnd_result                   combinational datapath result
//   out_valid/out_ready/out_data plaintext output handshake
//   busy                         high while rounds are in progress
module aes_dec_iter_ctrl
  import aes_dec_iter_ctrl_pkg::*;
#(
  parameter int N         = 256,
  parameter int NumRounds = 14,
  parameter int Numkeys   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [AES_BLK_W-1:0]               in_data,
  input  logic [AES_BLK_W*(NumRounds+1)-1:0] expandedkeys,
  input  logic [N-1:0]                       sbox_seed,
  output logic [AES_BLK_W-1:0]               rnd_state,
  output logic [AES_BLK_W-1:0]               rnd_key,
  output logic [7:0]                         rnd_num,
  output logic                               rnd_final,
  output logic [N-1:0]                       rnd_seed,
  input  logic [AES_BLK_W-1:0]               rnd_result,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [AES_BLK_W-1:0]               out_data,
  output logic                               busy
);

  localparam int CW = $clog2(NumRounds + 1);
  localparam logic [CW-1:0] LastCnt = CW'(NumRounds);

  // A single round cannot distinguish the first and final round steps.
  if (NumRounds < 2 || Numkeys < 1) begin : g_bad_cfg
    $error("aes_dec_iter_ctrl: NumRounds must be >= 2 and Numkeys >= 1");
  end

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [AES_BLK_W-1:0] st_q, st_d;
  logic [N-1:0]         sd_q, sd_d;
  logic                 out_valid_q, out_valid_d;
  logic                 accept;

  aes_dec_key_mux #(
    .NumRounds (NumRounds),
    .CW        (CW)
  ) u_key_mux (
    .expandedkeys (expandedkeys),
    .cnt          (cnt_q),
    .key          (rnd_key)
  );

  // DONE can hand off straight to the next block when the consumer takes the
  // current one, which gives one block per NumRounds+1 cycles.
  assign in_ready = !rst && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  assign rnd_state = st_q;
  assign rnd_seed  = sd_q;
  assign rnd_final = (cnt_q == LastCnt);
  // Decryption walks the cipher's round numbering backwards.
  assign rnd_num   = 8'(NumRounds + 1) - 8'(cnt_q);
  assign out_data  = st_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == S_RUN);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    st_d        = st_q;
    sd_d        = sd_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_RUN: begin
        st_d = rnd_result;
        if (cnt_q == LastCnt) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      S_IDLE: ;
      default: state_d = S_IDLE;
    endcase

    // Initial addRoundKey is done here so the datapath only sees full rounds.
    if (accept) begin
      st_d        = in_data ^ expandedkeys[AES_BLK_W-1:0];
      sd_d        = sbox_seed;
      cnt_d       = CW'(1);
      state_d     = S_RUN;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      st_q        <= '0;
      sd_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      st_q        <= st_d;
      sd_q        <= sd_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef AES_DEC_ROUND_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_RUN) begin
      $display("aes_dec_iter_ctrl: round cnt=%0d st=%h", cnt_q, st_d);
    end
    if (!rst && out_valid_d && !out_valid_q) begin
      $display("aes_dec_iter_ctrl: out_data=%h", st_d);
    end
  end
`else
`endif

endmodule
